queue_wr_arbiter: RTL and testbench
===================================

Name: queue_wr_arbiter

Overview:
Round-robin write arbiter that shares one 16-bit queue write port among N_REQ producers. It uses a valid/ready handshake on each requester port and a one-entry output register that drives the queue's write/din. It honours the queue's full flag, so no granted word is ever lost or duplicated. It sits directly in front of the queue's write side; the queue's read side is untouched.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, data width; matches the queue's din width
ID_W, 2, width of the requester index; must be at least clog2(N_REQ)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  reset, synchronous, active-high
req_valid  input  N_REQ  bit i: requester i has a word on req_data slice i
req_data  input  N_REQ*DATA_W  requester i's word is in bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  bit i: requester i's word is taken this cycle (combinational)
q_full  input  1  queue full flag
q_write  output  1  write strobe to queue (registered)
q_din  output  DATA_W  data to queue (registered)
q_src_id  output  ID_W  index of the requester whose word is on q_din
stall_cnt  output  16  saturating count of cycles with q_write=1 and q_full=1

Behaviour:
- Reset: when reset=1 at a clock edge, the following are cleared at that edge.
  - q_write=0, q_din=0, q_src_id=0, rr_ptr=0, stall_cnt=0.
  - req_ready is forced to all zeros while reset=1.
- Reset mid-operation: any word held in the output register is discarded. The requester already saw ready for it, so the word is lost by design.
- Output register: out_valid is the q_write register.
  - slot_free = !q_write || !q_full, i.e. the register is empty or is draining this cycle.
- Grant (combinational):
  - If slot_free, scan req_valid starting at rr_ptr with wrap-around and stop at the first set bit, g.
  - req_ready[g]=1; all other ready bits are 0.
  - If no bit is set or slot_free=0, req_ready is all zeros.
- Clock edge when a grant occurs:
  - q_write<=1, q_din<=word of requester g, q_src_id<=g.
  - rr_ptr<=(g+1) mod N_REQ.
- Clock edge with no grant:
  - If q_write=1 and q_full=0, then q_write<=0; q_din and q_src_id hold their values.
  - If q_write=1 and q_full=1, everything holds (back-pressure).
  - rr_ptr holds.
- Latency and throughput:
  - A word accepted at cycle t appears with q_write=1 at cycle t+1.
  - It is written into the queue at the end of the first cycle with q_write=1 and q_full=0.
  - Sustained rate is 1 word per cycle while the queue is not full.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,... Each requester waits at most N_REQ-1 grants.
- Handshake rules:
  - A requester must hold req_valid and req_data stable until it sees ready.
  - Dropping valid before ready is allowed; that word is simply never taken.
  - req_ready never depends on req_ready from any other module.
- q_full behaviour:
  - q_full=1 with q_write=0 still allows a grant. The word parks in the register until q_full falls.
  - Hence at most one word ever waits outside the queue.
- stall_cnt:
  - Increments by 1 each cycle in which q_write=1 and q_full=1.
  - Saturates at 16'hFFFF and never wraps.
  - Cleared only by reset.
- Widths:
  - rr_ptr is ID_W bits; wrap is an explicit compare against N_REQ-1, not natural overflow.
  - Unused ID codes when N_REQ is not a power of 2 are never produced.
- q_write is never asserted with stale data. Each word appears on q_write exactly once from grant until the queue accepts it.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then all req_valid=0. Required: q_write=0, q_din=0, req_ready=0000, stall_cnt=0 for 10 cycles.
- Single requester stream: req_valid=0010 with data 16'h1000..16'h1004 over 5 cycles, q_full=0. Required: req_ready[1]=1 each cycle; q_write=1 from cycle+1; q_din follows 1000..1004 back-to-back; q_src_id=1.
- Round-robin: req_valid=1111 continuous, data 16'hA000+i, q_full=0. Required: q_src_id sequence 0,1,2,3,0,1,2,3 and exactly one ready bit per cycle.
- Back-pressure: a word 16'hBEEF is in the register when q_full=1 is held for 4 cycles. Required: q_write=1 and q_din=BEEF held; req_ready=0000; stall_cnt=4. When q_full drops, the next word is granted the same cycle.
- Reset mid-stall: q_write=1 with q_full=1, then reset=1 for one cycle. Required: next cycle q_write=0, stall_cnt=0, rr_ptr=0, so the first grant after reset goes to requester 0 when all are valid.
- Saturation: q_full=1 with a parked word for 70000 cycles. Required: stall_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/queue_wr_arbiter.sv
// Purpose : round-robin arbiter merging N_REQ valid/ready producers onto one queue write port.
// Latency : a word accepted in cycle t is on q_write/q_din in cycle t+1; one word per cycle sustained.
// Backpr. : q_full with q_write=1 holds the output register and withholds every req_ready.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_valid/req_data  per-requester offer; requester i owns req_data[i*DATA_W +: DATA_W]
//   req_ready           one-hot (or zero) combinational grant; a set bit means the word is taken
//   q_full              queue full flag
//   q_write/q_din       registered write strobe and data to the queue
//   q_src_id            requester index of the word currently on q_din
//   stall_cnt           saturating count of cycles with q_write=1 and q_full=1
module queue_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2     // must be at least clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    q_full,
    output logic                    q_write,
    output logic [DATA_W-1:0]       q_din,
    output logic [ID_W-1:0]         q_src_id,
    output logic [15:0]             stall_cnt
);

    logic [ID_W-1:0] rr_ptr;
    logic            slot_free;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] rr_ptr_nxt;

    // Index base+off reduced modulo N_REQ; off never exceeds N_REQ-1 so one
    // subtraction is enough, and codes >= N_REQ are never produced.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    // The register can take a new word when empty or when its word drains this cycle.
    assign slot_free = !q_write || !q_full;

    // Scan from rr_ptr with wrap-around; the first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (slot_free && !reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_vld && req_valid[wrap_add(rr_ptr, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap_add(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Explicit wrap so non-power-of-two N_REQ never walks into unused codes.
    assign rr_ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_write  <= 1'b0;
            q_din    <= '0;
            q_src_id <= '0;
            rr_ptr   <= '0;
        end else if (grant_vld) begin
            q_write  <= 1'b1;
            q_din    <= req_data[grant_idx*DATA_W +: DATA_W];
            q_src_id <= grant_idx;
            rr_ptr   <= rr_ptr_nxt;
        end else if (q_write && !q_full) begin
            // Word drained with nothing to replace it; data/id keep their last value.
            q_write <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (q_write && q_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Purpose : directed bench for queue_wr_arbiter with a scoreboard of expected queue writes.
// Latency : stimulus drives 1 time unit after posedge; combinational checks 4 units after posedge.
// Backpr. : the monitor pops an expected word only on cycles with q_write=1 and q_full=0.
module tb_queue_wr_arbiter;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 16;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] dat;
    } exp_t;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    q_full;
    logic                    q_write;
    logic [DATA_W-1:0]       q_din;
    logic [ID_W-1:0]         q_src_id;
    logic [15:0]             stall_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    queue_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q_full    (q_full),
        .q_write   (q_write),
        .q_din     (q_din),
        .q_src_id  (q_src_id),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] dat);
        exp_t e;
        e.id  = id;
        e.dat = dat;
        sb.push_back(e);
    endtask

    // Monitor: every word the queue actually accepts must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && q_write && !q_full) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {14'd0, q_src_id, q_din}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("write_data", 32'(q_din), 32'(e.dat));
                chk("write_src", 32'(q_src_id), 32'(e.id));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        q_full    = 1'b0;

        // Reset: ready forced low even with all requesters valid.
        step();
        req_valid = 4'b1111;
        settle();
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        step();
        req_valid = '0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("idle_q_write", 32'(q_write), 32'h0);
            chk("idle_q_din", 32'(q_din), 32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_stall", 32'(stall_cnt), 32'h0);
            step();
        end

        // Single requester stream on port 1, back-to-back.
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0010;
            req_data[1*DATA_W +: DATA_W] = 16'(16'h1000 + i);
            push(2'd1, 16'(16'h1000 + i));
            settle();
            chk("stream_ready", 32'(req_ready), 32'h2);
            if (i > 0) begin
                chk("stream_q_write", 32'(q_write), 32'h1);
                chk("stream_q_din", 32'(q_din), 32'(16'h1000 + i - 1));
                chk("stream_src", 32'(q_src_id), 32'h1);
            end
            step();
        end
        req_valid = '0;
        settle();
        chk("stream_last_din", 32'(q_din), 32'h1004);
        step();
        settle();
        chk("stream_drained", 32'(q_write), 32'h0);
        chk("stream_din_hold", 32'(q_din), 32'h1004);

        // Reset to put rr_ptr at 0, then all four requesters continuously valid.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int j = 0; j < N_REQ; j++) req_data[j*DATA_W +: DATA_W] = 16'(16'hA000 + j);
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b1111;
            push(2'(k % 4), 16'(16'hA000 + (k % 4)));
            settle();
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
        end
        req_valid = '0;
        step();
        step();

        // Back-pressure: BEEF parks while q_full is high for 4 cycles.
        req_valid = 4'b0001;
        req_data[0 +: DATA_W] = 16'hBEEF;
        push(2'd0, 16'hBEEF);
        settle();
        chk("bp_first_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b0100;
        req_data[2*DATA_W +: DATA_W] = 16'h2222;
        q_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_q_write", 32'(q_write), 32'h1);
            chk("bp_q_din", 32'(q_din), 32'hBEEF);
            chk("bp_stall", 32'(stall_cnt), 32'(i));
            step();
        end
        q_full = 1'b0;
        push(2'd2, 16'h2222);
        settle();
        chk("bp_stall4", 32'(stall_cnt), 32'h4);
        chk("bp_release_ready", 32'(req_ready), 32'h4);
        chk("bp_release_din", 32'(q_din), 32'hBEEF);
        step();
        req_valid = '0;
        settle();
        chk("bp_next_din", 32'(q_din), 32'h2222);
        chk("bp_next_src", 32'(q_src_id), 32'h2);
        chk("bp_stall_hold", 32'(stall_cnt), 32'h4);
        step();
        step();

        // Reset mid-stall: parked 5555 is discarded, pointer returns to 0.
        req_valid = 4'b0010;
        req_data[1*DATA_W +: DATA_W] = 16'h5555;
        settle();
        chk("rst_mid_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        q_full = 1'b1;
        step();
        reset = 1'b1;
        settle();
        chk("rst_mid_parked", 32'(q_write), 32'h1);
        chk("rst_mid_stall_pre", 32'(stall_cnt), 32'h5);
        step();
        reset = 1'b0;
        q_full = 1'b0;
        req_valid = 4'b1111;
        for (int j = 0; j < N_REQ; j++) req_data[j*DATA_W +: DATA_W] = 16'(16'hA000 + j);
        push(2'd0, 16'hA000);
        settle();
        chk("rst_mid_q_write", 32'(q_write), 32'h0);
        chk("rst_mid_stall", 32'(stall_cnt), 32'h0);
        chk("rst_mid_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        settle();
        chk("rst_mid_src", 32'(q_src_id), 32'h0);
        chk("rst_mid_din", 32'(q_din), 32'hA000);
        step();
        step();

        // Saturation: park 3333 and hold q_full beyond 65535 cycles.
        req_valid = 4'b1000;
        req_data[3*DATA_W +: DATA_W] = 16'h3333;
        push(2'd3, 16'h3333);
        step();
        req_valid = '0;
        q_full = 1'b1;
        for (int i = 0; i < 65540; i++) step();
        settle();
        chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
        chk("sat_q_din", 32'(q_din), 32'h3333);
        for (int i = 0; i < 10; i++) step();
        settle();
        chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);
        chk("sat_ready", 32'(req_ready), 32'h0);
        step();
        q_full = 1'b0;
        step();
        step();
        settle();
        chk("sat_drained", 32'(q_write), 32'h0);
        chk("sat_stall_final", 32'(stall_cnt), 32'hFFFF);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
